gold_shift_sequencer: RTL and testbench

- Multi-channel successor to the single-channel Gold-code shift generator.
- Each frame period, emits a sequence of QUA+1 code-shift words per channel over a valid/ready stream, for the downstream Gold-code correlators/modulators.
- Adds per-channel offsets, a configurable step with modulo-N wrap, continuous or single-shot framing, a gating window and overrun detection.

---
 rtl/gold_shift_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_gold_shift_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gold_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gold_shift_sequencer
//  Description : Multi-channel Gold-code shift sequencer. Once per frame
//                period it streams QUA+1 code-shift words per channel over a
//                valid/ready interface. Each channel has its own base offset,
//                words advance by STEP modulo N, and the block provides
//                continuous or single-shot framing, a transmit gating window
//                and sticky overrun detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module gold_shift_sequencer #(
    parameter int N          = 63,
    parameter int LENGTH     = $clog2(N),
    parameter int QUA        = 10,
    parameter int CHANNELS   = 2,
    parameter int STEP       = 1,
    parameter int OFFSET     = 5,
    parameter int HOLD       = 4,
    parameter int NUM_CYCLES = 100000
) (
    input  logic                         clkin,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         mode_i,
    input  logic                         start_i,
    input  logic                         tready_i,
    output logic                         tvalid_o,
    output logic [CHANNELS*LENGTH-1:0]   code_o,
    output logic                         last_o,
    output logic                         gating_o,
    output logic                         busy_o,
    output logic                         overrun_o
);

    localparam int c_KW = (QUA > 0) ? $clog2(QUA + 1) : 1;
    localparam int c_TW = (NUM_CYCLES > 1) ? $clog2(NUM_CYCLES) : 1;
    localparam int c_HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam int c_AW = LENGTH + 1;

    localparam logic [c_KW-1:0] c_QUA       = c_KW'(QUA);
    localparam logic [c_TW-1:0] c_RELOAD    = c_TW'(NUM_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST = (HOLD > 0) ? c_HW'(HOLD - 1) : '0;
    localparam logic [c_AW-1:0] c_STEP      = c_AW'(STEP);
    localparam logic [c_AW-1:0] c_N         = c_AW'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_TW-1:0]   r_timer;
    logic              r_arm;
    logic [c_KW-1:0]   r_k, w_k_nxt;
    logic [c_HW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_gating, w_gating_nxt;
    logic              r_last, w_last_nxt;
    logic              r_overrun, w_overrun_nxt;

    logic              w_tick;
    logic              w_accept;
    logic              w_hs;
    logic              w_load;
    logic              w_adv;

    assign w_tick   = en_i && (r_timer == '0);
    assign w_accept = w_tick && (!mode_i || r_arm);
    assign w_hs     = r_valid && tready_i;

    // Frame timer: held at zero while disabled, ticks on the first enabled
    // cycle and then once every NUM_CYCLES cycles.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!en_i) begin
            r_timer <= '0;
        end else if (r_timer == '0) begin
            r_timer <= c_RELOAD;
        end else begin
            r_timer <= r_timer - 1'b1;
        end
    end

    // Single-shot arm flag: a start request wins over consumption so a pulse
    // coinciding with an accepted tick is not lost.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_arm <= 1'b0;
        end else if (start_i) begin
            r_arm <= 1'b1;
        end else if (w_tick && mode_i && r_arm) begin
            r_arm <= 1'b0;
        end
    end

    // Sequencer state and registered stream outputs.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_gating  <= 1'b0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_gating  <= w_gating_nxt;
            r_last    <= w_last_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Next-state logic: frame start, word advance, tail countdown, overrun.
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        w_gating_nxt  = r_gating;
        w_overrun_nxt = r_overrun;
        w_load        = 1'b0;
        w_adv         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = S_RUN;
                    w_load       = 1'b1;
                    w_k_nxt      = '0;
                    w_valid_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_gating_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (w_hs && (r_k == c_QUA)) begin
                    if (w_accept) begin
                        // New frame lands exactly on the final handshake:
                        // back-to-back frames, not an overrun.
                        w_load  = 1'b1;
                        w_k_nxt = '0;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        if (HOLD == 0) begin
                            w_state_nxt  = S_IDLE;
                            w_gating_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_TAIL;
                        end
                    end
                end else if (w_accept) begin
                    // Period expired with words still pending: restart the
                    // sequence in place and flag it.
                    w_overrun_nxt = 1'b1;
                    w_load        = 1'b1;
                    w_k_nxt       = '0;
                end else if (w_hs) begin
                    w_adv   = 1'b1;
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_TAIL: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                    w_k_nxt     = '0;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt  = S_IDLE;
                    w_gating_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_last_nxt = w_valid_nxt && (w_k_nxt == c_QUA);
    end

    // Per-channel shift accumulators: base reload at frame start, modulo-N
    // step on every accepted word.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [LENGTH-1:0] c_BASE = LENGTH'((c * OFFSET) % N);

        logic [LENGTH-1:0] r_acc;
        logic [c_AW-1:0]   w_sum;
        logic [LENGTH-1:0] w_wrap;

        assign w_sum  = {1'b0, r_acc} + c_STEP;
        assign w_wrap = (w_sum >= c_N) ? LENGTH'(w_sum - c_N) : LENGTH'(w_sum);

        // Accumulator register for this channel.
        always_ff @(posedge clkin) begin
            if (rst) begin
                r_acc <= '0;
            end else if (w_load) begin
                r_acc <= c_BASE;
            end else if (w_adv) begin
                r_acc <= w_wrap;
            end
        end

        assign code_o[c*LENGTH +: LENGTH] = r_acc;
    end

    assign tvalid_o  = r_valid;
    assign last_o    = r_last;
    assign gating_o  = r_gating;
    assign busy_o    = r_busy;
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_gold_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gold_shift_sequencer
//  Description : Self-checking bench for gold_shift_sequencer. Two instances
//                (STEP=1 and STEP=20) share one stimulus stream and are
//                compared every cycle against a behavioural frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gold_shift_sequencer;

    localparam int N          = 63;
    localparam int LENGTH     = 6;
    localparam int QUA        = 3;
    localparam int CHANNELS   = 2;
    localparam int OFFSET     = 5;
    localparam int HOLD       = 2;
    localparam int NUM_CYCLES = 20;
    localparam int STEP_A     = 1;
    localparam int STEP_B     = 20;

    logic clkin    = 1'b0;
    logic rst      = 1'b1;
    logic en_i     = 1'b0;
    logic mode_i   = 1'b0;
    logic start_i  = 1'b0;
    logic tready_i = 1'b1;

    logic                       tvalid_a, last_a, gating_a, busy_a, overrun_a;
    logic [CHANNELS*LENGTH-1:0] code_a;
    logic                       tvalid_b, last_b, gating_b, busy_b, overrun_b;
    logic [CHANNELS*LENGTH-1:0] code_b;

    always #5 clkin = ~clkin;

    gold_shift_sequencer #(
        .N(N), .LENGTH(LENGTH), .QUA(QUA), .CHANNELS(CHANNELS), .STEP(STEP_A),
        .OFFSET(OFFSET), .HOLD(HOLD), .NUM_CYCLES(NUM_CYCLES)
    ) dut_a (
        .clkin(clkin), .rst(rst), .en_i(en_i), .mode_i(mode_i), .start_i(start_i),
        .tready_i(tready_i), .tvalid_o(tvalid_a), .code_o(code_a), .last_o(last_a),
        .gating_o(gating_a), .busy_o(busy_a), .overrun_o(overrun_a)
    );

    gold_shift_sequencer #(
        .N(N), .LENGTH(LENGTH), .QUA(QUA), .CHANNELS(CHANNELS), .STEP(STEP_B),
        .OFFSET(OFFSET), .HOLD(HOLD), .NUM_CYCLES(NUM_CYCLES)
    ) dut_b (
        .clkin(clkin), .rst(rst), .en_i(en_i), .mode_i(mode_i), .start_i(start_i),
        .tready_i(tready_i), .tvalid_o(tvalid_b), .code_o(code_b), .last_o(last_b),
        .gating_o(gating_b), .busy_o(busy_b), .overrun_o(overrun_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_code(input int c, input int k, input int step);
        return (c * OFFSET + k * step) % N;
    endfunction

    // Behavioural model: word index, cycles since final handshake, enabled
    // cycles into the current period.
    int m_phase     = 0;
    int m_k         = 0;
    int m_tail      = 0;
    bit m_valid     = 1'b0;
    bit m_gate      = 1'b0;
    bit m_ovr       = 1'b0;
    bit m_arm       = 1'b0;
    bit m_code_zero = 1'b1;

    always @(posedge clkin) begin
        bit tick, acc, hs;
        if (rst) begin
            m_phase = 0; m_k = 0; m_tail = 0; m_valid = 0; m_gate = 0;
            m_ovr = 0; m_arm = 0; m_code_zero = 1;
        end else begin
            tick = en_i && (m_phase == 0);
            acc  = tick && (!mode_i || m_arm);
            hs   = m_valid && tready_i;
            if (start_i) m_arm = 1;
            else if (acc && mode_i) m_arm = 0;
            m_phase = en_i ? (m_phase + 1) % NUM_CYCLES : 0;
            if (m_valid) begin
                if (acc) begin
                    if (!(hs && m_k == QUA)) m_ovr = 1;
                    m_k = 0;
                end else if (hs) begin
                    if (m_k == QUA) begin
                        m_valid = 0;
                        m_tail  = 0;
                        m_gate  = (HOLD > 0);
                    end else begin
                        m_k++;
                    end
                end
            end else if (acc) begin
                m_valid = 1; m_k = 0; m_gate = 1; m_code_zero = 0;
            end else if (m_gate) begin
                m_tail++;
                if (m_tail == HOLD) m_gate = 0;
            end
        end
    end

    // Compare both instances against the model away from the active edge.
    always @(negedge clkin) begin
        if (chk_on) begin
            check_eq("tvalid_a",  tvalid_a,  m_valid);
            check_eq("busy_a",    busy_a,    m_valid);
            check_eq("last_a",    last_a,    m_valid && (m_k == QUA));
            check_eq("gating_a",  gating_a,  m_gate);
            check_eq("overrun_a", overrun_a, m_ovr);
            check_eq("tvalid_b",  tvalid_b,  m_valid);
            check_eq("busy_b",    busy_b,    m_valid);
            check_eq("last_b",    last_b,    m_valid && (m_k == QUA));
            check_eq("gating_b",  gating_b,  m_gate);
            check_eq("overrun_b", overrun_b, m_ovr);
            for (int c = 0; c < CHANNELS; c++) begin
                if (m_valid) begin
                    check_eq($sformatf("code_a_ch%0d", c), code_a[c*LENGTH +: LENGTH],
                             exp_code(c, m_k, STEP_A));
                    check_eq($sformatf("code_b_ch%0d", c), code_b[c*LENGTH +: LENGTH],
                             exp_code(c, m_k, STEP_B));
                end else if (m_code_zero) begin
                    check_eq($sformatf("code_a_rst_ch%0d", c), code_a[c*LENGTH +: LENGTH], 0);
                    check_eq($sformatf("code_b_rst_ch%0d", c), code_b[c*LENGTH +: LENGTH], 0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    initial begin
        int rdy_pct;
        int seg_len;
        step(1);
        chk_on = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);

        // Continuous frames with full throughput.
        en_i = 1'b1;
        step(50);

        // Three-cycle stall at word 1.
        for (int i = 0; i < 40 && !(m_valid && m_k == 1); i++) step(1);
        tready_i = 1'b0;
        step(3);
        tready_i = 1'b1;
        step(30);

        // Downstream blocked for more than a full period.
        tready_i = 1'b0;
        step(45);
        tready_i = 1'b1;
        step(30);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // Single-shot: nothing without start, then exactly one frame.
        mode_i = 1'b1;
        step(65);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        step(70);
        mode_i = 1'b0;

        // Reset in the middle of a frame.
        for (int i = 0; i < 40 && !(m_valid && m_k == 2); i++) step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(30);

        // Randomised segments.
        for (int seg = 0; seg < 40; seg++) begin
            en_i   = ($urandom_range(0, 9) != 0);
            mode_i = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       rdy_pct = 100;
                1:       rdy_pct = 75;
                2:       rdy_pct = 40;
                default: rdy_pct = 5;
            endcase
            seg_len = $urandom_range(20, 80);
            for (int i = 0; i < seg_len; i++) begin
                tready_i = ($urandom_range(0, 99) < rdy_pct);
                start_i  = ($urandom_range(0, 19) == 0);
                rst      = ($urandom_range(0, 149) == 0);
                step(1);
            end
        end
        rst      = 1'b0;
        start_i  = 1'b0;
        tready_i = 1'b1;
        step(10);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
